m_wb_uarttx: RTL and testbench

//  Wishbone-classic slave peripheral downstream of the midgetv core data bus: 8N1 UART transmitter.

---
 rtl/uarttx_pkg.sv | 11 +
 rtl/m_uarttx_fifo.sv | 36 +++
 rtl/m_wb_uarttx.sv | 107 ++++++++++
 tb/tb_m_wb_uarttx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uarttx_pkg.sv
// uarttx_pkg: shared FSM states, register word offsets and status bit positions for m_wb_uarttx
package uarttx_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic ADR_DATA = 1'b0;
   localparam logic ADR_DIV  = 1'b1;
   localparam int ST_EMPTY    = 0;
   localparam int ST_FULL     = 1;
   localparam int ST_BUSY     = 2;
   localparam int ST_TXIDLE   = 3;
   localparam int ST_OVERFLOW = 4;
endpackage

// File: rtl/m_uarttx_fifo.sv
// m_uarttx_fifo: 8-bit synchronous FIFO, head presented combinationally
module m_uarttx_fifo #(
   parameter int AW = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   logic [7:0]  mem [2**AW];
   logic [AW-1:0] wp, rp;
   logic [AW:0] n;
   logic        pw, pp;
   assign full  = n[AW];
   assign empty = n == '0;
   assign dout  = mem[rp];
   assign pw    = push & ~full;
   assign pp    = pop & ~empty;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         n  <= '0;
      end else begin
         if (pw) wp <= wp + 1'b1;
         if (pp) rp <= rp + 1'b1;
         n <= n + (AW+1)'(pw) - (AW+1)'(pp);
      end
   // storage needs no reset: pointers alone define the contents
   always_ff @(posedge clk)
      if (pw) mem[wp] <= din;
endmodule

// File: rtl/m_wb_uarttx.sv
// m_wb_uarttx: Wishbone-classic 8N1 UART transmitter with byte FIFO.
// Define UARTTX_RUNTIME_DIV_EN to make the baud divisor writable at ADR_I=1.
module m_wb_uarttx
   import uarttx_pkg::*;
#(
   parameter int FIFODEPTHLOG2 = 2,
   parameter int DIVWIDTH      = 16,
   parameter int DEFAULT_DIV   = 3
) (
   input  logic        CLK_I,
   input  logic        RSTN_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [3:0]  SEL_I,
   input  logic        ADR_I,
   input  logic [31:0] DAT_I,
   output logic [31:0] DAT_O,
   output logic        ACK_O,
   output logic        TXD,
   output logic        txidle
);
   state_t              state, state_nx;
   logic                acc, wr_data, pop, full, empty, busy, overflow;
   logic [7:0]          head, sh, sh_nx;
   logic [2:0]          bitn, bitn_nx;
   logic [DIVWIDTH-1:0] div, cnt, cnt_nx;
   logic [4:0]          stat;
   logic [31:0]         rdata;
   logic                unused_ok;

   assign acc     = STB_I & ~ACK_O;
   assign wr_data = acc & WE_I & (ADR_I == ADR_DATA) & SEL_I[0];
   assign busy    = state != IDLE;
   assign txidle  = empty & ~busy;
   assign TXD     = state == START ? 1'b0 : state == DATA ? sh[0] : 1'b1;
   assign unused_ok = ^{DAT_I, SEL_I};

   assign stat[ST_EMPTY]    = empty;
   assign stat[ST_FULL]     = full;
   assign stat[ST_BUSY]     = busy;
   assign stat[ST_TXIDLE]   = txidle;
   assign stat[ST_OVERFLOW] = overflow;
   assign rdata = ADR_I == ADR_DIV ? 32'(div) : 32'(stat);

   m_uarttx_fifo #(.AW(FIFODEPTHLOG2)) u_fifo (
      .clk(CLK_I), .rst_n(RSTN_I), .push(wr_data), .pop(pop),
      .din(DAT_I[7:0]), .dout(head), .full(full), .empty(empty)
   );

   always_ff @(posedge CLK_I or negedge RSTN_I)
      if (!RSTN_I) begin
         ACK_O    <= 1'b0;
         DAT_O    <= '0;
         overflow <= 1'b0;
      end else begin
         ACK_O    <= acc;
         DAT_O    <= acc & ~WE_I ? rdata : '0;
         // a drop in the same cycle as a status read keeps the flag set
         overflow <= wr_data & full ? 1'b1 : acc & ~WE_I & (ADR_I == ADR_DATA) ? 1'b0 : overflow;
      end

`ifdef UARTTX_RUNTIME_DIV_EN
   always_ff @(posedge CLK_I or negedge RSTN_I)
      if (!RSTN_I)
         div <= DIVWIDTH'(DEFAULT_DIV);
      else if (acc & WE_I & (ADR_I == ADR_DIV))
         for (int i = 0; i < DIVWIDTH; i++)
            if (SEL_I[i/8]) div[i] <= DAT_I[i];
`else
   assign div = DIVWIDTH'(DEFAULT_DIV);
`endif

   always_ff @(posedge CLK_I or negedge RSTN_I)
      if (!RSTN_I) begin
         state <= IDLE;
         cnt   <= '0;
         bitn  <= '0;
         sh    <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         bitn  <= bitn_nx;
         sh    <= sh_nx;
      end

   // end of stop bit chains straight into the next start bit when data waits
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      bitn_nx  = bitn;
      sh_nx    = sh;
      pop      = 1'b0;
      if (state == IDLE || (state == STOP && cnt == '0)) begin
         pop      = ~empty;
         sh_nx    = empty ? sh : head;
         cnt_nx   = empty ? cnt : div;
         state_nx = empty ? IDLE : START;
      end else if (cnt != '0)
         cnt_nx = cnt - 1'b1;
      else begin
         cnt_nx   = div;
         state_nx = state == START ? DATA : bitn == 3'd7 ? STOP : DATA;
         bitn_nx  = state == START ? 3'd0 : bitn + 1'b1;
         sh_nx    = state == START ? sh : sh >> 1;
      end
   end
endmodule

// File: tb/tb_m_wb_uarttx.sv
// tb_m_wb_uarttx: directed bench for m_wb_uarttx (FIFODEPTHLOG2=2, DEFAULT_DIV=3)
module tb_m_wb_uarttx;
   logic        CLK_I = 1'b0, RSTN_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0, ADR_I = 1'b0;
   logic [3:0]  SEL_I = '0;
   logic [31:0] DAT_I = '0, DAT_O;
   logic        ACK_O, TXD, txidle;
   int          checks = 0, failures = 0, cyc = 0;
   logic        txlog [0:8191];

   typedef struct {
      logic        we;
      logic        adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [6];

   m_wb_uarttx dut (
      .CLK_I(CLK_I), .RSTN_I(RSTN_I), .STB_I(STB_I), .WE_I(WE_I), .SEL_I(SEL_I),
      .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .TXD(TXD), .txidle(txidle)
   );

   always #5 CLK_I = ~CLK_I;

   always @(negedge CLK_I) begin
      if (cyc < 8192) txlog[cyc] = TXD;
      cyc++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic bus(input logic we, input logic adr, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rd);
      logic ack1;
      STB_I = 1'b1; WE_I = we; ADR_I = adr; SEL_I = sel; DAT_I = dat;
      @(negedge CLK_I);
      ack1 = ACK_O;
      rd = DAT_O;
      STB_I = 1'b0; WE_I = 1'b0;
      @(negedge CLK_I);
      chk("ack_rise", {31'b0, ack1}, 1);
      chk("ack_fall", {31'b0, ACK_O}, 0);
   endtask

   task automatic check_high(input string nm, input int from, input int to);
      int bad = 0;
      for (int i = from; i < to; i++) if (txlog[i] !== 1'b1) bad++;
      chk(nm, bad, 0);
   endtask

   task automatic check_frame(input string nm, input int from, input logic [7:0] b,
                              input int div, input bit exact, output int nxt);
      int st = -1;
      logic [9:0] bits = {1'b1, b, 1'b0};
      if (exact) st = (txlog[from] === 1'b0) ? from : -1;
      else
         for (int i = from; i < cyc && i < from + 200; i++)
            if (st < 0 && txlog[i] === 1'b0) st = i;
      chk({nm, "_start"}, {31'b0, st >= 0}, 1);
      if (st < 0) st = from;
      for (int k = 0; k < 10; k++) begin
         logic act = bits[k];
         for (int j = 0; j <= div; j++)
            if (txlog[st + k*(div+1) + j] !== bits[k]) act = txlog[st + k*(div+1) + j];
         chk($sformatf("%s_bit%0d", nm, k), {31'b0, act}, {31'b0, bits[k]});
      end
      nxt = st + 10*(div+1);
   endtask

   initial begin
      logic [31:0] rd;
      int mark, n1, n2;
      logic [7:0] ob [6];
      tbl[0] = '{1'b0, 1'b0, 4'b0001, 32'h0,  32'h09};
      tbl[1] = '{1'b0, 1'b1, 4'b0011, 32'h0,  32'h03};
      tbl[2] = '{1'b1, 1'b0, 4'b1110, 32'hAA, 32'h00};
      tbl[3] = '{1'b0, 1'b0, 4'b1111, 32'h0,  32'h09};
      tbl[4] = '{1'b1, 1'b1, 4'b0000, 32'h7,  32'h00};
      tbl[5] = '{1'b0, 1'b1, 4'b0011, 32'h0,  32'h03};
      ob = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      repeat (3) @(negedge CLK_I);
      chk("rst_txd", {31'b0, TXD}, 1);
      chk("rst_txidle", {31'b0, txidle}, 1);
      chk("rst_ack", {31'b0, ACK_O}, 0);
      chk("rst_dato", DAT_O, 0);
      RSTN_I = 1'b1;
      @(negedge CLK_I);

      for (int i = 0; i < 6; i++) begin
         bus(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd);
         chk($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end

`ifndef UARTTX_RUNTIME_DIV_EN
      bus(1'b1, 1'b1, 4'b0011, 32'h0, rd);
      bus(1'b0, 1'b1, 4'b0011, 32'h0, rd);
      chk("div_const", rd, 32'h3);
`endif

      mark = cyc;
      bus(1'b1, 1'b0, 4'b0001, 32'h55, rd);
      repeat (50) @(negedge CLK_I);
      check_frame("f55", mark, 8'h55, 3, 1'b0, n1);
      chk("f55_txidle", {31'b0, txidle}, 1);
      bus(1'b0, 1'b0, 4'b0001, 32'h0, rd);
      chk("f55_status", rd, 32'h09);

      mark = cyc;
      bus(1'b1, 1'b0, 4'b0001, 32'hA1, rd);
      bus(1'b1, 1'b0, 4'b0001, 32'hB2, rd);
      repeat (90) @(negedge CLK_I);
      check_frame("fa1", mark, 8'hA1, 3, 1'b0, n1);
      check_frame("fb2", n1, 8'hB2, 3, 1'b1, n2);
      chk("two_frame_len", n2 - (n1 - 40), 80);

      mark = cyc;
      for (int i = 0; i < 6; i++) bus(1'b1, 1'b0, 4'b0001, {24'b0, ob[i]}, rd);
      bus(1'b0, 1'b0, 4'b0001, 32'h0, rd);
      chk("ovf_status", rd, 32'h16);
      bus(1'b0, 1'b0, 4'b0001, 32'h0, rd);
      chk("ovf_cleared", rd, 32'h06);
      repeat (220) @(negedge CLK_I);
      check_frame("ovf0", mark, ob[0], 3, 1'b0, n1);
      for (int i = 1; i < 5; i++) check_frame($sformatf("ovf%0d", i), n1, ob[i], 3, 1'b1, n1);
      check_high("no_6th_frame", n1, cyc);
      chk("ovf_txidle", {31'b0, txidle}, 1);

`ifdef UARTTX_RUNTIME_DIV_EN
      bus(1'b1, 1'b1, 4'b0011, 32'h0, rd);
      bus(1'b0, 1'b1, 4'b0011, 32'h0, rd);
      chk("div_read0", rd, 32'h0);
      mark = cyc;
      bus(1'b1, 1'b0, 4'b0001, 32'hFF, rd);
      repeat (20) @(negedge CLK_I);
      check_frame("fff", mark, 8'hFF, 0, 1'b0, n1);
      chk("fff_txidle", {31'b0, txidle}, 1);
`endif

      bus(1'b1, 1'b0, 4'b0001, 32'h00, rd);
      bus(1'b1, 1'b0, 4'b0001, 32'h0F, rd);
      repeat (4) @(negedge CLK_I);
      chk("pre_rst_txd", {31'b0, TXD}, 0);
      RSTN_I = 1'b0;
      #1;
      chk("mid_rst_txd", {31'b0, TXD}, 1);
      chk("mid_rst_txidle", {31'b0, txidle}, 1);
      repeat (2) @(negedge CLK_I);
      RSTN_I = 1'b1;
      @(negedge CLK_I);
      bus(1'b0, 1'b0, 4'b0001, 32'h0, rd);
      chk("post_rst_status", rd, 32'h09);
      mark = cyc;
      repeat (60) @(negedge CLK_I);
      check_high("no_residual", mark, cyc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
